// File: rtl/rs_multi_issue.sv
`default_nettype none
// ============================================================================
// Module   : rs_multi_issue
// Brief    : Multi-issue reservation station: result-bus wakeup, oldest-first
//            per-FU selection, dispatch back-pressure and flush.
//            Optional RS_STATS_EN adds stat_stall / stat_issued counters.
// Revision : 1.0 - initial release
// ============================================================================
module rs_multi_issue #(
   parameter int DEPTH         = 16,
   parameter int NUM_FU        = 3,
   parameter int NUM_BUS       = 2,
   parameter int PREG_WIDTH    = 6,
   parameter int DATA_WIDTH    = 32,
   parameter int ROB_WIDTH     = 6,
   parameter int PAYLOAD_WIDTH = 64,
   localparam int FU_W         = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
   localparam int c_cnt_w      = $clog2(DEPTH) + 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic                              disp_valid,
   output logic                              disp_ready,
   input  logic [FU_W-1:0]                   disp_fu,
   input  logic [PREG_WIDTH-1:0]             disp_rd,
   input  logic [PREG_WIDTH-1:0]             disp_src1,
   input  logic [PREG_WIDTH-1:0]             disp_src2,
   input  logic [DATA_WIDTH-1:0]             disp_data1,
   input  logic [DATA_WIDTH-1:0]             disp_data2,
   input  logic                              disp_rdy1,
   input  logic                              disp_rdy2,
   input  logic [ROB_WIDTH-1:0]              disp_rob,
   input  logic [PAYLOAD_WIDTH-1:0]          disp_payload,
   input  logic [NUM_BUS-1:0]                bus_valid,
   input  logic [NUM_BUS*PREG_WIDTH-1:0]     bus_rd,
   input  logic [NUM_BUS*DATA_WIDTH-1:0]     bus_data,
   input  logic [NUM_FU-1:0]                 fu_ready,
   output logic [NUM_FU-1:0]                 issue_valid,
   output logic [NUM_FU*PREG_WIDTH-1:0]      issue_rd,
   output logic [NUM_FU*DATA_WIDTH-1:0]      issue_data1,
   output logic [NUM_FU*DATA_WIDTH-1:0]      issue_data2,
   output logic [NUM_FU*ROB_WIDTH-1:0]       issue_rob,
   output logic [NUM_FU*PAYLOAD_WIDTH-1:0]   issue_payload,
`ifdef RS_STATS_EN
   output logic [31:0]                       stat_stall,
   output logic [31:0]                       stat_issued,
`endif
   output logic [c_cnt_w-1:0]                count
);

   localparam int                 c_idx_w = $clog2(DEPTH);
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

   // Entry storage
   logic [DEPTH-1:0]         r_valid;
   logic [DEPTH-1:0]         r_rdy1;
   logic [DEPTH-1:0]         r_rdy2;
   logic [FU_W-1:0]          r_fu      [DEPTH];
   logic [PREG_WIDTH-1:0]    r_rd      [DEPTH];
   logic [PREG_WIDTH-1:0]    r_src1    [DEPTH];
   logic [PREG_WIDTH-1:0]    r_src2    [DEPTH];
   logic [DATA_WIDTH-1:0]    r_data1   [DEPTH];
   logic [DATA_WIDTH-1:0]    r_data2   [DEPTH];
   logic [ROB_WIDTH-1:0]     r_rob     [DEPTH];
   logic [PAYLOAD_WIDTH-1:0] r_payload [DEPTH];
   // r_older[i][j] set means entry i was dispatched before entry j
   logic [DEPTH-1:0]         r_older   [DEPTH];
   logic [c_cnt_w-1:0]       r_count;

   // Issue registers
   logic [NUM_FU-1:0]               r_issue_valid;
   logic [NUM_FU*PREG_WIDTH-1:0]    r_issue_rd;
   logic [NUM_FU*DATA_WIDTH-1:0]    r_issue_data1;
   logic [NUM_FU*DATA_WIDTH-1:0]    r_issue_data2;
   logic [NUM_FU*ROB_WIDTH-1:0]     r_issue_rob;
   logic [NUM_FU*PAYLOAD_WIDTH-1:0] r_issue_payload;

   // Lowest-index bus wins when several broadcast the same tag
   function automatic logic [DATA_WIDTH:0] bus_lookup(
      input logic [PREG_WIDTH-1:0]         tag,
      input logic [NUM_BUS-1:0]            vld,
      input logic [NUM_BUS*PREG_WIDTH-1:0] tags,
      input logic [NUM_BUS*DATA_WIDTH-1:0] data
   );
      logic [DATA_WIDTH:0] res;
      res = '0;
      for (int b = NUM_BUS - 1; b >= 0; b--) begin
         if (vld[b] && (tags[b*PREG_WIDTH +: PREG_WIDTH] == tag))
            res = {1'b1, data[b*DATA_WIDTH +: DATA_WIDTH]};
      end
      return res;
   endfunction

   logic [DEPTH-1:0]      w_hit1;
   logic [DEPTH-1:0]      w_hit2;
   logic [DATA_WIDTH-1:0] w_wdata1 [DEPTH];
   logic [DATA_WIDTH-1:0] w_wdata2 [DEPTH];
   logic                  w_dhit1;
   logic                  w_dhit2;
   logic [DATA_WIDTH-1:0] w_ddata1;
   logic [DATA_WIDTH-1:0] w_ddata2;

   always_comb begin
      w_hit1 = '0;
      w_hit2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         {w_hit1[i], w_wdata1[i]} = bus_lookup(r_src1[i], bus_valid, bus_rd, bus_data);
         {w_hit2[i], w_wdata2[i]} = bus_lookup(r_src2[i], bus_valid, bus_rd, bus_data);
      end
      {w_dhit1, w_ddata1} = bus_lookup(disp_src1, bus_valid, bus_rd, bus_data);
      {w_dhit2, w_ddata2} = bus_lookup(disp_src2, bus_valid, bus_rd, bus_data);
   end

   // Dispatch control
   logic               w_disp_ready;
   logic               w_fu_ok;
   logic               w_accept;
   logic [c_idx_w-1:0] w_free_idx;

   assign w_disp_ready = (r_count < c_depth);
   assign w_fu_ok      = (32'(disp_fu) < 32'(NUM_FU));
   assign w_accept     = disp_valid && w_disp_ready && !flush && w_fu_ok;

   always_comb begin
      w_free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i])
            w_free_idx = c_idx_w'(i);
      end
   end

   // Selection: a candidate wins when no other candidate of its FU is older
   logic [DEPTH-1:0] w_col   [DEPTH];
   logic [DEPTH-1:0] w_grant [NUM_FU];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_col[i] = '0;
         for (int j = 0; j < DEPTH; j++)
            w_col[i][j] = r_older[j][i];
      end
   end

   always_comb begin
      logic [DEPTH-1:0] cand;
      cand = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         w_grant[k] = '0;
         for (int i = 0; i < DEPTH; i++)
            cand[i] = r_valid[i] & r_rdy1[i] & r_rdy2[i] & fu_ready[k]
                      & (r_fu[i] == FU_W'(k));
         for (int i = 0; i < DEPTH; i++)
            w_grant[k][i] = cand[i] & ~(|(cand & w_col[i]));
      end
   end

   logic [DEPTH-1:0]         w_issue_mask;
   logic [NUM_FU-1:0]        w_fu_fire;
   logic [c_cnt_w-1:0]       w_num_issued;
   logic [PREG_WIDTH-1:0]    w_sel_rd      [NUM_FU];
   logic [DATA_WIDTH-1:0]    w_sel_data1   [NUM_FU];
   logic [DATA_WIDTH-1:0]    w_sel_data2   [NUM_FU];
   logic [ROB_WIDTH-1:0]     w_sel_rob     [NUM_FU];
   logic [PAYLOAD_WIDTH-1:0] w_sel_payload [NUM_FU];

   always_comb begin
      w_issue_mask = '0;
      w_fu_fire    = '0;
      w_num_issued = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         w_sel_rd[k]      = '0;
         w_sel_data1[k]   = '0;
         w_sel_data2[k]   = '0;
         w_sel_rob[k]     = '0;
         w_sel_payload[k] = '0;
         w_fu_fire[k]     = |w_grant[k];
         w_issue_mask     = w_issue_mask | w_grant[k];
         w_num_issued     = w_num_issued + c_cnt_w'(w_fu_fire[k]);
         for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[k][i]) begin
               w_sel_rd[k]      = r_rd[i];
               w_sel_data1[k]   = r_data1[i];
               w_sel_data2[k]   = r_data2[i];
               w_sel_rob[k]     = r_rob[i];
               w_sel_payload[k] = r_payload[i];
            end
         end
      end
   end

   // Entry state: wakeup, free on issue, then dispatch into the pre-edge free slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_rdy1  <= '0;
         r_rdy2  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_fu[i]      <= '0;
            r_rd[i]      <= '0;
            r_src1[i]    <= '0;
            r_src2[i]    <= '0;
            r_data1[i]   <= '0;
            r_data2[i]   <= '0;
            r_rob[i]     <= '0;
            r_payload[i] <= '0;
            r_older[i]   <= '0;
         end
      end else if (flush) begin
         r_valid <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_rdy1[i] && w_hit1[i]) begin
               r_rdy1[i]  <= 1'b1;
               r_data1[i] <= w_wdata1[i];
            end
            if (r_valid[i] && !r_rdy2[i] && w_hit2[i]) begin
               r_rdy2[i]  <= 1'b1;
               r_data2[i] <= w_wdata2[i];
            end
            if (w_issue_mask[i])
               r_valid[i] <= 1'b0;
            if (w_accept) begin
               if (w_free_idx == c_idx_w'(i)) begin
                  r_valid[i]   <= 1'b1;
                  r_fu[i]      <= disp_fu;
                  r_rd[i]      <= disp_rd;
                  r_src1[i]    <= disp_src1;
                  r_src2[i]    <= disp_src2;
                  r_rdy1[i]    <= disp_rdy1 | w_dhit1;
                  r_rdy2[i]    <= disp_rdy2 | w_dhit2;
                  r_data1[i]   <= (!disp_rdy1 && w_dhit1) ? w_ddata1 : disp_data1;
                  r_data2[i]   <= (!disp_rdy2 && w_dhit2) ? w_ddata2 : disp_data2;
                  r_rob[i]     <= disp_rob;
                  r_payload[i] <= disp_payload;
                  r_older[i]   <= '0;
               end else begin
                  r_older[i][w_free_idx] <= 1'b1;
               end
            end
         end
         r_count <= r_count + c_cnt_w'(w_accept) - w_num_issued;
      end
   end

   // Issue bundles hold their last value when an FU does not fire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_valid   <= '0;
         r_issue_rd      <= '0;
         r_issue_data1   <= '0;
         r_issue_data2   <= '0;
         r_issue_rob     <= '0;
         r_issue_payload <= '0;
      end else if (flush) begin
         r_issue_valid <= '0;
      end else begin
         r_issue_valid <= w_fu_fire;
         for (int k = 0; k < NUM_FU; k++) begin
            if (w_fu_fire[k]) begin
               r_issue_rd[k*PREG_WIDTH +: PREG_WIDTH]            <= w_sel_rd[k];
               r_issue_data1[k*DATA_WIDTH +: DATA_WIDTH]         <= w_sel_data1[k];
               r_issue_data2[k*DATA_WIDTH +: DATA_WIDTH]         <= w_sel_data2[k];
               r_issue_rob[k*ROB_WIDTH +: ROB_WIDTH]             <= w_sel_rob[k];
               r_issue_payload[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= w_sel_payload[k];
            end
         end
      end
   end

`ifdef RS_STATS_EN
   logic [31:0] r_stat_stall;
   logic [31:0] r_stat_issued;
   logic [32:0] w_issued_sum;

   always_comb begin
      w_issued_sum = {1'b0, r_stat_issued};
      for (int k = 0; k < NUM_FU; k++)
         w_issued_sum = w_issued_sum + 33'(r_issue_valid[k]);
   end

   // Saturating counters, cleared by reset only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_stall  <= '0;
         r_stat_issued <= '0;
      end else begin
         if (disp_valid && !w_disp_ready && (r_stat_stall != '1))
            r_stat_stall <= r_stat_stall + 32'd1;
         r_stat_issued <= w_issued_sum[32] ? '1 : w_issued_sum[31:0];
      end
   end

   assign stat_stall  = r_stat_stall;
   assign stat_issued = r_stat_issued;
`endif

   assign disp_ready    = w_disp_ready;
   assign count         = r_count;
   assign issue_valid   = r_issue_valid;
   assign issue_rd      = r_issue_rd;
   assign issue_data1   = r_issue_data1;
   assign issue_data2   = r_issue_data2;
   assign issue_rob     = r_issue_rob;
   assign issue_payload = r_issue_payload;

endmodule
`default_nettype wire

// File: tb/tb_rs_multi_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_multi_issue
// Brief    : Directed self-checking bench for rs_multi_issue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_multi_issue;

   localparam int DEPTH = 4;
   localparam int NUM_FU = 3;
   localparam int NUM_BUS = 2;
   localparam int PW = 6;
   localparam int DW = 32;
   localparam int RW = 6;
   localparam int YW = 64;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic            disp_valid;
   logic            disp_ready;
   logic [1:0]      disp_fu;
   logic [PW-1:0]   disp_rd, disp_src1, disp_src2;
   logic [DW-1:0]   disp_data1, disp_data2;
   logic            disp_rdy1, disp_rdy2;
   logic [RW-1:0]   disp_rob;
   logic [YW-1:0]   disp_payload;
   logic [NUM_BUS-1:0]       bus_valid;
   logic [NUM_BUS*PW-1:0]    bus_rd;
   logic [NUM_BUS*DW-1:0]    bus_data;
   logic [NUM_FU-1:0]        fu_ready;
   logic [NUM_FU-1:0]        issue_valid;
   logic [NUM_FU*PW-1:0]     issue_rd;
   logic [NUM_FU*DW-1:0]     issue_data1, issue_data2;
   logic [NUM_FU*RW-1:0]     issue_rob;
   logic [NUM_FU*YW-1:0]     issue_payload;
   logic [2:0]               count;
`ifdef RS_STATS_EN
   logic [31:0]              stat_stall, stat_issued;
`endif

   int vectors = 0;
   int errors  = 0;

   rs_multi_issue #(
      .DEPTH(DEPTH), .NUM_FU(NUM_FU), .NUM_BUS(NUM_BUS), .PREG_WIDTH(PW),
      .DATA_WIDTH(DW), .ROB_WIDTH(RW), .PAYLOAD_WIDTH(YW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
      .disp_rd(disp_rd), .disp_src1(disp_src1), .disp_src2(disp_src2),
      .disp_data1(disp_data1), .disp_data2(disp_data2),
      .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
      .disp_rob(disp_rob), .disp_payload(disp_payload),
      .bus_valid(bus_valid), .bus_rd(bus_rd), .bus_data(bus_data),
      .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_data1(issue_data1), .issue_data2(issue_data2),
      .issue_rob(issue_rob), .issue_payload(issue_payload),
`ifdef RS_STATS_EN
      .stat_stall(stat_stall), .stat_issued(stat_issued),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_disp(input logic [1:0] fu, input logic [PW-1:0] s1, input logic r1,
                           input logic [DW-1:0] d1, input logic [PW-1:0] s2, input logic r2,
                           input logic [DW-1:0] d2, input logic [RW-1:0] rob);
      disp_fu = fu; disp_src1 = s1; disp_rdy1 = r1; disp_data1 = d1;
      disp_src2 = s2; disp_rdy2 = r2; disp_data2 = d2; disp_rob = rob;
      disp_rd = rob ^ 6'h3F;
      disp_payload = {32'hCAFEF00D, 26'd0, rob};
   endtask

   task automatic clear_inputs();
      flush = 0; disp_valid = 0; bus_valid = '0; bus_rd = '0; bus_data = '0;
      fu_ready = 3'b111;
      set_disp(2'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0);
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      #1;
      vectors++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      vectors++; if (issue_valid !== 3'b000) begin errors++; $display("FAIL reset_issue_valid: got %b expected 000", issue_valid); end
      vectors++; if (issue_data1 !== '0) begin errors++; $display("FAIL reset_bundle: got %h expected 0", issue_data1); end
      tick(); tick();
      @(negedge clk); rst_n = 1;
      tick();
      vectors++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b expected 1", disp_ready); end
   endtask

   task automatic test_ready_dispatch();
      set_disp(2'd0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 6'd4);
      disp_valid = 1; tick(); disp_valid = 0;
      vectors++; if (count !== 3'd1) begin errors++; $display("FAIL ready_count1: got %0d expected 1", count); end
      vectors++; if (issue_valid !== 3'b000) begin errors++; $display("FAIL ready_early: got %b expected 000", issue_valid); end
      tick();
      vectors++; if (issue_valid !== 3'b001) begin errors++; $display("FAIL ready_issue: got %b expected 001", issue_valid); end
      vectors++; if (issue_data1[31:0] !== 32'd5) begin errors++; $display("FAIL ready_data1: got %0d expected 5", issue_data1[31:0]); end
      vectors++; if (issue_data2[31:0] !== 32'd7) begin errors++; $display("FAIL ready_data2: got %0d expected 7", issue_data2[31:0]); end
      vectors++; if (issue_rob[5:0] !== 6'd4) begin errors++; $display("FAIL ready_rob: got %0d expected 4", issue_rob[5:0]); end
      vectors++; if (issue_rd[5:0] !== 6'h3B) begin errors++; $display("FAIL ready_rd: got %h expected 3b", issue_rd[5:0]); end
      vectors++; if (issue_payload[63:0] !== 64'hCAFEF00D_00000004) begin errors++; $display("FAIL ready_payload: got %h expected cafef00d00000004", issue_payload[63:0]); end
      vectors++; if (count !== 3'd0) begin errors++; $display("FAIL ready_count0: got %0d expected 0", count); end
      tick();
      vectors++; if (issue_valid !== 3'b000) begin errors++; $display("FAIL ready_pulse: got %b expected 000", issue_valid); end
      vectors++; if (issue_data1[31:0] !== 32'd5) begin errors++; $display("FAIL ready_hold: got %0d expected 5", issue_data1[31:0]); end
   endtask

   task automatic test_wakeup();
      set_disp(2'd2, 6'd12, 1'b0, 32'd0, 6'd3, 1'b1, 32'd3, 6'd5);
      disp_valid = 1; tick(); disp_valid = 0;
      bus_valid = 2'b10; bus_rd = {6'd12, 6'd0}; bus_data = {32'h0000ABCD, 32'd0};
      tick(); bus_valid = 2'b00;
      vectors++; if (issue_valid !== 3'b000) begin errors++; $display("FAIL wake_no_same_cycle: got %b expected 000", issue_valid); end
      tick();
      vectors++; if (issue_valid !== 3'b100) begin errors++; $display("FAIL wake_issue: got %b expected 100", issue_valid); end
      vectors++; if (issue_data1[64 +: 32] !== 32'h0000ABCD) begin errors++; $display("FAIL wake_data1: got %h expected abcd", issue_data1[64 +: 32]); end
      vectors++; if (issue_data2[64 +: 32] !== 32'd3) begin errors++; $display("FAIL wake_data2: got %h expected 3", issue_data2[64 +: 32]); end
      set_disp(2'd2, 6'd12, 1'b0, 32'd0, 6'd3, 1'b1, 32'd3, 6'd6);
      disp_valid = 1; tick(); disp_valid = 0;
      bus_valid = 2'b11; bus_rd = {6'd12, 6'd12}; bus_data = {32'd2, 32'd1};
      tick(); bus_valid = 2'b00;
      tick();
      vectors++; if (issue_valid !== 3'b100) begin errors++; $display("FAIL wake2_issue: got %b expected 100", issue_valid); end
      vectors++; if (issue_data1[64 +: 32] !== 32'd1) begin errors++; $display("FAIL wake2_bus_priority: got %0d expected 1", issue_data1[64 +: 32]); end
   endtask

   task automatic test_bypass();
      set_disp(2'd1, 6'd4, 1'b1, 32'd8, 6'd9, 1'b0, 32'd0, 6'd7);
      bus_valid = 2'b01; bus_rd = {6'd0, 6'd9}; bus_data = {32'd0, 32'd42};
      disp_valid = 1; tick(); disp_valid = 0; bus_valid = 2'b00;
      vectors++; if (count !== 3'd1) begin errors++; $display("FAIL bypass_count: got %0d expected 1", count); end
      tick();
      vectors++; if (issue_valid !== 3'b010) begin errors++; $display("FAIL bypass_issue: got %b expected 010", issue_valid); end
      vectors++; if (issue_data2[32 +: 32] !== 32'd42) begin errors++; $display("FAIL bypass_data2: got %0d expected 42", issue_data2[32 +: 32]); end
      vectors++; if (issue_data1[32 +: 32] !== 32'd8) begin errors++; $display("FAIL bypass_data1: got %0d expected 8", issue_data1[32 +: 32]); end
   endtask

   task automatic test_drop();
      set_disp(2'd3, 6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd1, 6'd9);
      disp_valid = 1; tick(); disp_valid = 0;
      vectors++; if (count !== 3'd0) begin errors++; $display("FAIL drop_count: got %0d expected 0", count); end
      tick();
      vectors++; if (issue_valid !== 3'b000) begin errors++; $display("FAIL drop_issue: got %b expected 000", issue_valid); end
   endtask

   task automatic test_oldest_first();
      logic [RW-1:0] exp_rob [3];
      exp_rob[0] = 6'd1; exp_rob[1] = 6'd2; exp_rob[2] = 6'd3;
      fu_ready = 3'b000;
      set_disp(2'd0, 6'd1, 1'b1, 32'd0, 6'd1, 1'b1, 32'd0, 6'd10);
      disp_valid = 1; tick();
      set_disp(2'd1, 6'd20, 1'b0, 32'd0, 6'd1, 1'b1, 32'd0, 6'd1); tick();
      set_disp(2'd1, 6'd20, 1'b0, 32'd0, 6'd1, 1'b1, 32'd0, 6'd2); tick();
      disp_valid = 0; fu_ready = 3'b001; tick();
      vectors++; if (issue_valid !== 3'b001 || issue_rob[5:0] !== 6'd10) begin errors++; $display("FAIL oldest_x: got %b/%0d expected 001/10", issue_valid, issue_rob[5:0]); end
      set_disp(2'd1, 6'd20, 1'b0, 32'd0, 6'd1, 1'b1, 32'd0, 6'd3);
      disp_valid = 1; fu_ready = 3'b111; tick(); disp_valid = 0;
      vectors++; if (count !== 3'd3) begin errors++; $display("FAIL oldest_count: got %0d expected 3", count); end
      bus_valid = 2'b01; bus_rd = {6'd0, 6'd20}; bus_data = {32'd0, 32'h55};
      tick(); bus_valid = 2'b00;
      for (int n = 0; n < 3; n++) begin
         tick();
         vectors++; if (issue_valid !== 3'b010 || issue_rob[6 +: 6] !== exp_rob[n]) begin errors++; $display("FAIL oldest_order%0d: got %b/%0d expected 010/%0d", n, issue_valid, issue_rob[6 +: 6], exp_rob[n]); end
      end
      vectors++; if (issue_data1[32 +: 32] !== 32'h55) begin errors++; $display("FAIL oldest_data: got %h expected 55", issue_data1[32 +: 32]); end
      vectors++; if (count !== 3'd0) begin errors++; $display("FAIL oldest_drain: got %0d expected 0", count); end
   endtask

   task automatic test_full_and_flush();
      fu_ready = 3'b000;
      disp_valid = 1;
      for (int n = 0; n < 4; n++) begin
         set_disp(2'd0, 6'd1, 1'b1, 32'(n), 6'd2, 1'b1, 32'd0, 6'(8 + n));
         tick();
      end
      vectors++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
      vectors++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", disp_ready); end
      set_disp(2'd0, 6'd1, 1'b1, 32'd99, 6'd2, 1'b1, 32'd0, 6'd12);
      tick();
      vectors++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject: got %0d expected 4", count); end
`ifdef RS_STATS_EN
      vectors++; if (stat_stall !== 32'd1) begin errors++; $display("FAIL stat_stall: got %0d expected 1", stat_stall); end
`endif
      fu_ready = 3'b001;
      vectors++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru: got %b expected 0", disp_ready); end
      tick(); disp_valid = 0; fu_ready = 3'b000;
      vectors++; if (issue_valid !== 3'b001 || issue_rob[5:0] !== 6'd8) begin errors++; $display("FAIL full_issue: got %b/%0d expected 001/8", issue_valid, issue_rob[5:0]); end
      vectors++; if (count !== 3'd3) begin errors++; $display("FAIL full_count3: got %0d expected 3", count); end
      // Flush with an issue candidate and a dispatch pending in the same cycle
      flush = 1; disp_valid = 1; fu_ready = 3'b001; tick(); flush = 0; disp_valid = 0;
      vectors++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
      vectors++; if (issue_valid !== 3'b000) begin errors++; $display("FAIL flush_issue: got %b expected 000", issue_valid); end
`ifdef RS_STATS_EN
      vectors++; if (stat_issued !== 32'd9) begin errors++; $display("FAIL stat_issued: got %0d expected 9", stat_issued); end
`endif
      fu_ready = 3'b111; tick(); tick();
      vectors++; if (issue_valid !== 3'b000 || count !== 3'd0) begin errors++; $display("FAIL flush_after: got %b/%0d expected 000/0", issue_valid, count); end
   endtask

   task automatic test_reset_mid();
      fu_ready = 3'b000;
      set_disp(2'd0, 6'd1, 1'b1, 32'd77, 6'd2, 1'b1, 32'd0, 6'd20);
      disp_valid = 1; tick(); tick(); disp_valid = 0;
      fu_ready = 3'b001; tick();
      vectors++; if (issue_valid !== 3'b001 || count !== 3'd1) begin errors++; $display("FAIL mid_pre: got %b/%0d expected 001/1", issue_valid, count); end
      #2 rst_n = 0;
      #1;
      vectors++; if (count !== 3'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
      vectors++; if (issue_valid !== 3'b000) begin errors++; $display("FAIL mid_rst_valid: got %b expected 000", issue_valid); end
      vectors++; if (issue_data1[31:0] !== 32'd0 || issue_rob[5:0] !== 6'd0) begin errors++; $display("FAIL mid_rst_bundle: got %h/%0d expected 0/0", issue_data1[31:0], issue_rob[5:0]); end
      vectors++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", disp_ready); end
`ifdef RS_STATS_EN
      vectors++; if (stat_stall !== 32'd0 || stat_issued !== 32'd0) begin errors++; $display("FAIL mid_rst_stats: got %0d/%0d expected 0/0", stat_stall, stat_issued); end
`endif
      @(negedge clk); rst_n = 1;
      tick();
      vectors++; if (issue_valid !== 3'b000 || count !== 3'd0) begin errors++; $display("FAIL mid_release: got %b/%0d expected 000/0", issue_valid, count); end
   endtask

   initial begin
      test_reset();
      test_ready_dispatch();
      test_wakeup();
      test_bypass();
      test_drop();
      test_oldest_first();
      test_full_and_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
